// File: rtl/acc_pkg.sv
// -----------------------------------------------------------------------------
// acc_pkg
// Shared definitions for the accumulator-channel output stage: FSM state
// encoding, default sizes, a constant-function clog2 and the frame length
// helper.
// Configuration macro: SERIAL_PARITY_EN (appends one even-parity bit per frame).
// -----------------------------------------------------------------------------
package acc_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  // Number of bits needed to index 'value' distinct items (0 for value <= 1).
  function automatic int clog2(input int value);
    int result;
    int v;
    result = 0;
    v      = value - 1;
    while (v > 0) begin
      result = result + 1;
      v      = v >> 1;
    end
    return result;
  endfunction

`ifdef SERIAL_PARITY_EN
  localparam int PARITY_BITS = 1;
`else
  localparam int PARITY_BITS = 0;
`endif

  // Bits per frame: I word, Q word, optional trailing parity bit.
  function automatic int frame_len(input int acc_width);
    return 2 * acc_width + PARITY_BITS;
  endfunction

  localparam int ACC_WIDTH_DEF = 16;
  localparam int BUF_DEPTH_DEF = 2;
  localparam int FRAME_LEN     = frame_len(ACC_WIDTH_DEF);

endpackage : acc_pkg

// File: rtl/iq_frame_fifo.sv
// -----------------------------------------------------------------------------
// iq_frame_fifo
// Circular buffer of DEPTH words (one packed I/Q pair per word). DEPTH must be
// a power of two so the pointers wrap naturally. Push and pop in the same
// cycle are both honoured; the caller never pushes when full without popping
// and never pops when empty.
// Ports:
//   clk      in   shift clock
//   reset    in   asynchronous, active-high reset
//   push     in   write wr_data this cycle
//   wr_data  in   WIDTH-bit word to store
//   pop      in   consume the head word this cycle
//   rd_data  out  head word (valid when !empty)
//   full     out  DEPTH words held
//   empty    out  no words held
// -----------------------------------------------------------------------------
module iq_frame_fifo
  import acc_pkg::*;
#(
  parameter int WIDTH = 2 * ACC_WIDTH_DEF,
  parameter int DEPTH = BUF_DEPTH_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = clog2(DEPTH);
  localparam int CNT_W = clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;

  // NOTE: storage is intentionally not reset; pointers and count alone say which entries are valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign rd_data = mem[rd_ptr];
  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);

endmodule : iq_frame_fifo

// File: rtl/iq_frame_serializer.sv
// -----------------------------------------------------------------------------
// iq_frame_serializer
// Output stage of one accumulator channel. Decimated I/Q pairs are queued in a
// small frame buffer and shifted off-chip MSB-first as I then Q, one bit per
// clk, with serialStart marking the first bit of every frame. Frames queued
// behind the current one follow with no idle bit.
// Configuration macro: SERIAL_PARITY_EN -- when defined each frame carries one
// extra trailing bit holding the even parity (XOR) of all I/Q data bits.
// Ports:
//   clk          in   serial shift clock
//   reset        in   asynchronous, active-high reset
//   acc_I        in   in-phase accumulator word
//   acc_Q        in   quadrature accumulator word
//   load_valid   in   acc_I/acc_Q valid this cycle
//   load_ready   out  buffer can take a pair this cycle (not full, or popping)
//   serialStart  out  first bit of a frame on serialOut
//   serialOut    out  serial data, 0 when idle
//   busy         out  frame being shifted
//   overflow     out  sticky: a pair arrived while load_ready was low
// -----------------------------------------------------------------------------
module iq_frame_serializer
  import acc_pkg::*;
#(
  parameter int ACC_WIDTH = ACC_WIDTH_DEF,
  parameter int BUF_DEPTH = BUF_DEPTH_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [ACC_WIDTH-1:0] acc_I,
  input  logic [ACC_WIDTH-1:0] acc_Q,
  input  logic                 load_valid,
  output logic                 load_ready,
  output logic                 serialStart,
  output logic                 serialOut,
  output logic                 busy,
  output logic                 overflow
);

  localparam int WORD_W     = 2 * ACC_WIDTH;
  localparam int FRAME_BITS = frame_len(ACC_WIDTH);
  localparam int CNT_W      = clog2(FRAME_BITS);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(FRAME_BITS - 1);

  state_t                  state;
  state_t                  next_state;
  logic [CNT_W-1:0]        bit_cnt;
  logic [FRAME_BITS-1:0]   shreg;
  logic [FRAME_BITS-1:0]   frame_word;

  logic                    fifo_push;
  logic                    fifo_pop;
  logic                    fifo_full;
  logic                    fifo_empty;
  logic [WORD_W-1:0]       fifo_rd_data;

  logic                    load_frame;
  logic                    shift_bit;
  logic                    end_frame;

  // A slot freed by this cycle's pop can be refilled in the same cycle.
  assign load_ready = !fifo_full || fifo_pop;
  assign fifo_push  = load_valid && load_ready;

  iq_frame_fifo #(
    .WIDTH (WORD_W),
    .DEPTH (BUF_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (fifo_push),
    .wr_data ({acc_I, acc_Q}),
    .pop     (fifo_pop),
    .rd_data (fifo_rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

`ifdef SERIAL_PARITY_EN
  assign frame_word = {fifo_rd_data, ^fifo_rd_data};
`else
  assign frame_word = fifo_rd_data;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // The pop decision lives here: from IDLE whenever data waits, and from SHIFT
  // only while the last bit is on the pin, so the next frame follows gaplessly.
  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    next_state = state;
    fifo_pop   = 1'b0;
    load_frame = 1'b0;
    shift_bit  = 1'b0;
    end_frame  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop   = 1'b1;
          load_frame = 1'b1;
          next_state = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (bit_cnt == LAST_BIT) begin
          if (!fifo_empty) begin
            fifo_pop   = 1'b1;
            load_frame = 1'b1;
          end else begin
            end_frame  = 1'b1;
            next_state = ST_IDLE;
          end
        end else begin
          shift_bit = 1'b1;
        end
      end
      default: next_state = ST_IDLE;
    endcase
  end

  // serialOut holds the bit currently on the pin; shreg holds the bits still
  // to come, left-aligned so the next one is always at the MSB.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shreg       <= '0;
      bit_cnt     <= '0;
      serialOut   <= 1'b0;
      serialStart <= 1'b0;
      busy        <= 1'b0;
    end else if (load_frame) begin
      shreg       <= {frame_word[FRAME_BITS-2:0], 1'b0};
      bit_cnt     <= '0;
      serialOut   <= frame_word[FRAME_BITS-1];
      serialStart <= 1'b1;
      busy        <= 1'b1;
    end else if (shift_bit) begin
      shreg       <= {shreg[FRAME_BITS-2:0], 1'b0};
      bit_cnt     <= bit_cnt + 1'b1;
      serialOut   <= shreg[FRAME_BITS-1];
      serialStart <= 1'b0;
    end else if (end_frame) begin
      bit_cnt     <= '0;
      serialOut   <= 1'b0;
      serialStart <= 1'b0;
      busy        <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overflow <= 1'b0;
    end else if (load_valid && !load_ready) begin
      overflow <= 1'b1;
    end
  end

endmodule : iq_frame_serializer

// File: tb/tb_iq_frame_serializer.sv
// -----------------------------------------------------------------------------
// tb_iq_frame_serializer
// Directed bench for iq_frame_serializer (ACC_WIDTH=16, BUF_DEPTH=2). A queue
// based reference model predicts every output each cycle; logged outputs are
// also checked against hand-computed frames, start cycles and flags.
// Honours SERIAL_PARITY_EN the same way as the design.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_iq_frame_serializer;

  localparam int W = 16;
  localparam int D = 2;
`ifdef SERIAL_PARITY_EN
  localparam int FL = 2 * W + 1;
`else
  localparam int FL = 2 * W;
`endif
  localparam int LOG_N = 4096;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [W-1:0] acc_I;
  logic [W-1:0] acc_Q;
  logic         load_valid;
  logic         load_ready;
  logic         serialStart;
  logic         serialOut;
  logic         busy;
  logic         overflow;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  bit so_log [LOG_N];
  bit st_log [LOG_N];
  bit bz_log [LOG_N];
  bit rd_log [LOG_N];
  bit ov_log [LOG_N];

  // Reference model: pairs waiting, bits still to come, current pin values.
  logic [2*W-1:0] mbuf [$];
  bit             rem  [$];
  bit             m_start, m_out, m_busy, m_ovf;

  always #5 clk = ~clk;

  iq_frame_serializer #(
    .ACC_WIDTH (W),
    .BUF_DEPTH (D)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .acc_I       (acc_I),
    .acc_Q       (acc_Q),
    .load_valid  (load_valid),
    .load_ready  (load_ready),
    .serialStart (serialStart),
    .serialOut   (serialOut),
    .busy        (busy),
    .overflow    (overflow)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, exp);
    end
  endtask

  task automatic model_clear();
    mbuf.delete();
    rem.delete();
    m_start = 1'b0;
    m_out   = 1'b0;
    m_busy  = 1'b0;
    m_ovf   = 1'b0;
  endtask

  // Per-cycle compare against the model, then advance the model past the
  // coming clock edge using the inputs currently applied.
  initial begin
    bit             pop;
    bit             rdy;
    logic [2*W-1:0] w;
    forever begin
      @(negedge clk);
      if (!reset) begin
        pop = (!m_busy || rem.size() == 0) && mbuf.size() > 0;
        rdy = (mbuf.size() < D) || pop;
        check("serialStart", serialStart, m_start);
        check("serialOut",   serialOut,   m_out);
        check("busy",        busy,        m_busy);
        check("overflow",    overflow,    m_ovf);
        check("load_ready",  load_ready,  rdy);
        if (cyc < LOG_N) begin
          so_log[cyc] = serialOut;
          st_log[cyc] = serialStart;
          bz_log[cyc] = busy;
          rd_log[cyc] = load_ready;
          ov_log[cyc] = overflow;
        end
        if (load_valid && !rdy) m_ovf = 1'b1;
        w = '0;
        if (pop) w = mbuf.pop_front();
        if (load_valid && rdy) mbuf.push_back({acc_I, acc_Q});
        if (pop) begin
          rem.delete();
          for (int b = 2 * W - 1; b >= 0; b--) rem.push_back(w[b]);
`ifdef SERIAL_PARITY_EN
          rem.push_back(^w);
`endif
          m_out   = rem.pop_front();
          m_start = 1'b1;
          m_busy  = 1'b1;
        end else if (m_busy && rem.size() > 0) begin
          m_out   = rem.pop_front();
          m_start = 1'b0;
        end else begin
          m_out   = 1'b0;
          m_start = 1'b0;
          m_busy  = 1'b0;
        end
      end
      cyc++;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog cyc=%0d got=timeout want=finish", cyc);
    $fatal(1, "watchdog expired");
  end

  // Positions the driver just after a rising edge; cyc then names the cycle
  // whose falling edge samples whatever is driven now.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic go_to(input int k);
    while (cyc < k) step();
  endtask

  task automatic load(input logic [W-1:0] i, input logic [W-1:0] q, output int n);
    acc_I      = i;
    acc_Q      = q;
    load_valid = 1'b1;
    n          = cyc;
    step();
    load_valid = 1'b0;
  endtask

  function automatic logic [2*W-1:0] frame_data(input int s);
    logic [2*W-1:0] v;
    v = '0;
    for (int i = 0; i < 2 * W; i++) v = {v[2*W-2:0], so_log[s+i]};
    return v;
  endfunction

  function automatic int busy_count(input int s);
    int k;
    k = 0;
    while ((s + k) < LOG_N && bz_log[s+k]) k++;
    return k;
  endfunction

  function automatic int busy_any(input int s, input int len);
    int n;
    n = 0;
    for (int i = 0; i < len; i++) n += int'(bz_log[s+i]);
    return n;
  endfunction

  task automatic do_reset(input string tag);
    #2;
    reset = 1'b1;
    #1;
    check({tag, "_rst_start"}, serialStart, 1'b0);
    check({tag, "_rst_out"},   serialOut,   1'b0);
    check({tag, "_rst_busy"},  busy,        1'b0);
    check({tag, "_rst_ovf"},   overflow,    1'b0);
    check({tag, "_rst_ready"}, load_ready,  1'b1);
    model_clear();
    repeat (2) @(posedge clk);
    #3;
    reset = 1'b0;
    step();
  endtask

  initial begin
    int n, n2, n3, n4, s, last, rel;
    acc_I      = '0;
    acc_Q      = '0;
    load_valid = 1'b0;
    model_clear();

    // Reset state
    repeat (3) @(posedge clk);
    #3;
    check("reset_start", serialStart, 1'b0);
    check("reset_out",   serialOut,   1'b0);
    check("reset_busy",  busy,        1'b0);
    check("reset_ovf",   overflow,    1'b0);
    check("reset_ready", load_ready,  1'b1);
    reset = 1'b0;
    step();
    repeat (2) step();

    // 1: single frame, latency N+2, exact bits, busy length
    load(16'hA5A5, 16'h0F0F, n);
    s = n + 2;
    go_to(s + FL + 3);
    check("t1_no_early_start", st_log[s-1], 1'b0);
    check("t1_start",          st_log[s],   1'b1);
    check("t1_start_width",    st_log[s+1], 1'b0);
    check("t1_data",           frame_data(s), 32'hA5A50F0F);
    check("t1_busy_len",       busy_count(s), FL);
    check("t1_idle_out",       so_log[s+FL], 1'b0);
`ifdef SERIAL_PARITY_EN
    check("t1_parity",         so_log[s+32], 1'b0);
`endif

    // 2: loads 5 cycles apart -> back-to-back frames
    load(16'h1234, 16'h5678, n);
    repeat (4) step();
    load(16'hFEDC, 16'hBA98, n2);
    s = n + 2;
    go_to(s + 2 * FL + 3);
    check("t2_start1",   st_log[s],      1'b1);
    check("t2_start2",   st_log[s+FL],   1'b1);
    check("t2_no_gap",   busy_count(s),  2 * FL);
    check("t2_data1",    frame_data(s),      32'h12345678);
    check("t2_data2",    frame_data(s + FL), 32'hFEDCBA98);
`ifdef SERIAL_PARITY_EN
    check("t2_parity1",  so_log[s+32],      1'b1);
    check("t2_parity2",  so_log[s+FL+32],   1'b0);
`endif

    // 3: three pairs queued behind frame 1, fourth dropped
    load(16'h1111, 16'h2222, n);
    s = n + 2;
    go_to(n + 4);
    load(16'h3333, 16'h4444, n2);
    go_to(n + 8);
    load(16'h5555, 16'h6666, n3);
    go_to(n + 12);
    load(16'h7777, 16'h8888, n4);
    go_to(s + 3 * FL + 3);
    check("t3_load3_ready",  rd_log[n3], 1'b1);
    check("t3_load4_ready",  rd_log[n4], 1'b0);
    check("t3_ovf_before",   ov_log[n4], 1'b0);
    check("t3_ovf_set",      ov_log[n4+1], 1'b1);
    check("t3_ovf_sticky",   ov_log[s+3*FL+1], 1'b1);
    check("t3_frames_len",   busy_count(s), 3 * FL);
    check("t3_data1",        frame_data(s),          32'h11112222);
    check("t3_data2",        frame_data(s + FL),     32'h33334444);
    check("t3_data3",        frame_data(s + 2 * FL), 32'h55556666);
    check("t3_idle_after",   bz_log[s+3*FL], 1'b0);

    do_reset("clr");

    // 4: load on the last bit with the buffer full -> accepted
    load(16'hAAAA, 16'h5555, n);
    s    = n + 2;
    last = s + FL - 1;
    go_to(n + 3);
    load(16'h0F0F, 16'hF0F0, n2);
    go_to(n + 5);
    load(16'h1357, 16'h2468, n3);
    go_to(last);
    load(16'hCAFE, 16'hBEEF, n4);
    go_to(s + 4 * FL + 3);
    check("t4_ready_on_last", rd_log[last], 1'b1);
    check("t4_ovf_clear",     ov_log[last+1], 1'b0);
    check("t4_ovf_end",       ov_log[s+4*FL], 1'b0);
    check("t4_frames_len",    busy_count(s), 4 * FL);
    check("t4_data2",         frame_data(s + FL),     32'h0F0FF0F0);
    check("t4_data3",         frame_data(s + 2 * FL), 32'h13572468);
    check("t4_start4",        st_log[s+3*FL], 1'b1);
    check("t4_data4",         frame_data(s + 3 * FL), 32'hCAFEBEEF);

    // 5: reset at bit 10 with a second pair waiting
    load(16'hC3C3, 16'h3C3C, n);
    s = n + 2;
    go_to(n + 4);
    load(16'h6666, 16'h9999, n2);
    go_to(s + 10);
    check("t5_busy_bit10", busy, 1'b1);
    do_reset("t5");
    rel = cyc;
    repeat (6) step();
    check("t5_no_tail_or_stale", busy_any(rel, 6), 0);
    load(16'h8001, 16'h7FFE, n);
    s = n + 2;
    go_to(s + FL + 2);
    check("t5_no_early",  st_log[s-1], 1'b0);
    check("t5_start",     st_log[s],   1'b1);
    check("t5_data",      frame_data(s), 32'h80017FFE);
    check("t5_len",       busy_count(s), FL);

`ifdef SERIAL_PARITY_EN
    // 6: parity bit value and 33-bit frame length
    load(16'h0001, 16'h0000, n);
    s = n + 2;
    go_to(s + FL + 2);
    check("t6_parity_one",  so_log[s+32], 1'b1);
    check("t6_len_33",      busy_count(s), 33);
    load(16'h0003, 16'h0000, n);
    s = n + 2;
    go_to(s + FL + 2);
    check("t6_parity_zero", so_log[s+32], 1'b0);
    check("t6_data",        frame_data(s), 32'h00030000);
`endif

    repeat (3) step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_iq_frame_serializer
